// File: rtl/seg_display_arbiter_pkg.sv
// Shared constants for the 7-segment display arbiter: blank patterns,
// source index map, FSM state codes and counter sizing.
package seg_display_arbiter_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam int unsigned SRC_INPUT  = 0;
  localparam int unsigned SRC_RESULT = 1;
  localparam int unsigned SRC_ERROR  = 2;

  localparam logic [0:0] ST_OWN   = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  // Counter width large enough to hold the largest cycle limit without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seg_display_arbiter_src_prio_enc.sv
// Masked highest-index priority encoder; index 0 is the fallback when nothing
// eligible is requesting.
module src_prio_enc
  import seg_display_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] mask,
  output logic [IDX_W-1:0] target
);

  always_comb begin
    target = '0;
    for (int unsigned k = 1; k < N_SRC; k++) begin
      if (req[k] && !mask[k]) target = IDX_W'(k);
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Fixed-priority owner arbitration for the shared 4-digit display with
// minimum hold, blanking gap on every handover and optional ownership timeout.
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC       = 2,
  parameter int unsigned SEG_W       = 7,
  parameter int unsigned AN_W        = 4,
  parameter int unsigned BLANK_CYC   = 1000,
  parameter int unsigned HOLD_CYC    = 50000,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC-1:0]           req,
  input  logic [N_SRC*SEG_W-1:0]     seg_in,
  input  logic [N_SRC*AN_W-1:0]      an_in,
  input  logic [N_SRC-1:0]           dp_in,
  output logic [SEG_W-1:0]           seg,
  output logic [AN_W-1:0]            an,
  output logic                       dp,
  output logic [$clog2(N_SRC)-1:0]   owner,
  output logic                       blanking
);

  localparam int unsigned IDX_W = $clog2(N_SRC);
  localparam int unsigned CNT_W = cnt_width(BLANK_CYC, HOLD_CYC, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_V     = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] TO_V       = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [0:0]       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] blank_cnt;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mask_nxt;
  logic [IDX_W-1:0] target;

  logic             preempt, demote, timeout, leave;
  logic [SEG_W-1:0] own_seg, tgt_seg;
  logic [AN_W-1:0]  own_an,  tgt_an;
  logic             own_dp,  tgt_dp;

  src_prio_enc #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req    (req),
    .mask   (mask),
    .target (target)
  );

  always_comb begin
    own_seg = '1;
    own_an  = '1;
    own_dp  = 1'b1;
    tgt_seg = '1;
    tgt_an  = '1;
    tgt_dp  = 1'b1;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (owner == IDX_W'(k)) begin
        own_seg = seg_in[k*SEG_W +: SEG_W];
        own_an  = an_in[k*AN_W +: AN_W];
        own_dp  = dp_in[k];
      end
      if (target == IDX_W'(k)) begin
        tgt_seg = seg_in[k*SEG_W +: SEG_W];
        tgt_an  = an_in[k*AN_W +: AN_W];
        tgt_dp  = dp_in[k];
      end
    end
  end

  always_comb begin
    preempt = (target > owner);
    demote  = (target < owner) && (hold_cnt >= HOLD_V);
    timeout = (TIMEOUT_CYC != 0) && (owner != '0) && (hold_cnt >= TO_V);
    leave   = (state == ST_OWN) && (preempt || demote || timeout);
    // A timed-out owner stays masked until it drops its request once.
    mask_nxt = mask & req;
    if ((state == ST_OWN) && timeout) mask_nxt[owner] = 1'b1;
    mask_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_OWN;
      owner     <= '0;
      hold_cnt  <= '0;
      blank_cnt <= '0;
      mask      <= '0;
      seg       <= '1;
      an        <= '1;
      dp        <= 1'b1;
      blanking  <= 1'b0;
    end else begin
      mask <= mask_nxt;
      case (state)
        ST_OWN: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + CNT_W'(1);
          if (leave) begin
            state     <= ST_BLANK;
            blank_cnt <= '0;
            blanking  <= 1'b1;
            seg       <= '1;
            an        <= '1;
            dp        <= 1'b1;
          end else begin
            seg <= own_seg;
            an  <= own_an;
            dp  <= own_dp;
          end
        end
        default: begin
          // Target is only sampled on the final gap cycle; its data is loaded directly.
          if (blank_cnt == BLANK_LAST) begin
            state    <= ST_OWN;
            owner    <= target;
            hold_cnt <= '0;
            blanking <= 1'b0;
            seg      <= tgt_seg;
            an       <= tgt_an;
            dp       <= tgt_dp;
          end else begin
            blank_cnt <= blank_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed and random check of seg_display_arbiter (3 sources, gap 4, hold 8,
// timeout 20) against a cycle-count model plus hand-computed expectations.
module tb_seg_display_arbiter;

  localparam int unsigned NS    = 3;
  localparam int unsigned BLANK = 4;
  localparam int unsigned HOLD  = 8;
  localparam int unsigned TO    = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NS-1:0]   req = '0;
  logic [NS*7-1:0] seg_in;
  logic [NS*4-1:0] an_in;
  logic [NS-1:0]   dp_in;
  logic [6:0]      seg;
  logic [3:0]      an;
  logic            dp;
  logic [1:0]      owner;
  logic            blanking;
  bit              rand_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  seg_display_arbiter #(
    .N_SRC       (NS),
    .SEG_W       (7),
    .AN_W        (4),
    .BLANK_CYC   (BLANK),
    .HOLD_CYC    (HOLD),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .seg_in   (seg_in),
    .an_in    (an_in),
    .dp_in    (dp_in),
    .seg      (seg),
    .an       (an),
    .dp       (dp),
    .owner    (owner),
    .blanking (blanking)
  );

  always #5 clk = ~clk;

  // Model: owner, remaining gap cycles, cycles owned, sources barred after timeout.
  int unsigned m_owner, m_gap, m_ten;
  logic [NS-1:0] m_bar;
  logic [6:0]    m_seg;
  logic [3:0]    m_an;
  logic          m_dp;

  always @(posedge clk or negedge rst) begin
    int unsigned tgt;
    bit kick, go;
    if (!rst) begin
      m_owner = 0; m_gap = 0; m_ten = 0; m_bar = '0;
      m_seg = 7'h7F; m_an = 4'hF; m_dp = 1'b1;
    end else begin
      tgt = 0;
      for (int k = 1; k < NS; k++) if (req[k] && !m_bar[k]) tgt = k;
      if (m_gap == 0) begin
        kick = (TO > 0) && (m_owner != 0) && (m_ten + 1 >= TO);
        go   = (tgt > m_owner) || (tgt < m_owner && m_ten >= HOLD) || kick;
        m_bar = m_bar & req;
        if (kick) m_bar[m_owner] = 1'b1;
        m_bar[0] = 1'b0;
        m_ten++;
        if (go) begin
          m_gap = BLANK;
          m_seg = 7'h7F; m_an = 4'hF; m_dp = 1'b1;
        end else begin
          m_seg = seg_in[m_owner*7 +: 7]; m_an = an_in[m_owner*4 +: 4]; m_dp = dp_in[m_owner];
        end
      end else begin
        m_bar = m_bar & req;
        m_bar[0] = 1'b0;
        if (m_gap == 1) begin
          m_owner = tgt; m_ten = 0;
          m_seg = seg_in[tgt*7 +: 7]; m_an = an_in[tgt*4 +: 4]; m_dp = dp_in[tgt];
        end
        m_gap--;
      end
    end
  end

  always @(negedge clk) begin
    logic [14:0] act, exp;
    act = {seg, an, dp, owner, blanking};
    exp = {m_seg, m_an, m_dp, 2'(m_owner), (m_gap != 0)};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL model_cmp t=%0t got seg=%h an=%h dp=%b owner=%0d blank=%b expected seg=%h an=%h dp=%b owner=%0d blank=%b",
               $time, seg, an, dp, owner, blanking, m_seg, m_an, m_dp, m_owner, m_gap != 0);
    end
  end

  always @(negedge clk) begin
    #1;
    if (rand_en) begin
      seg_in = NS*7'($urandom);
      an_in  = NS*4'($urandom);
      dp_in  = NS'($urandom);
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    seg_in = {7'h33, 7'h22, 7'h11};
    an_in  = {4'hB, 4'hD, 4'hE};
    dp_in  = 3'b010;

    // Reset release: next edge shows source 0.
    tick(2);
    rst = 1'b1;
    tick(1);
    lit("post_reset_seg", 32'(seg), 32'h11);
    lit("post_reset_an_dp", 32'({an, dp}), 32'h1C);
    lit("post_reset_owner", 32'({owner, blanking}), 32'h0);
    tick(10);

    // Preemption by source 1: 4 blank cycles, then source 1 data.
    req[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      lit("preempt_gap", 32'({seg, blanking}), 32'hFF);
    end
    tick(1);
    lit("preempt_owner", 32'({owner, blanking}), 32'h2);
    lit("preempt_seg", 32'(seg), 32'h22);

    // Request drop at hold 3: no handover until hold reaches 8.
    tick(3);
    req[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      lit("hold_keep", 32'({owner, blanking}), 32'h2);
    end
    tick(1);
    lit("hold_gap_start", 32'(blanking), 32'h1);
    tick(4);
    lit("hold_owner0", 32'({owner, blanking}), 32'h0);

    // Source 2 preempts source 1 at hold 2.
    req[1] = 1'b1;
    tick(5);
    lit("own1_again", 32'({owner, blanking}), 32'h2);
    tick(2);
    req[2] = 1'b1;
    tick(1);
    lit("preempt2_gap", 32'(blanking), 32'h1);
    tick(4);
    lit("preempt2_owner", 32'({owner, blanking}), 32'h4);
    lit("preempt2_seg", 32'(seg), 32'h33);

    // Drop source 2; after hold the display returns to source 1, which then times out.
    req[2] = 1'b0;
    tick(9);
    lit("demote2_gap", 32'(blanking), 32'h1);
    tick(4);
    lit("timeout_start", 32'({owner, blanking}), 32'h2);
    for (int i = 0; i < 19; i++) begin
      tick(1);
      lit("timeout_hold", 32'({owner, blanking}), 32'h2);
    end
    tick(1);
    lit("timeout_gap", 32'(blanking), 32'h1);
    tick(4);
    lit("timeout_owner0", 32'({owner, blanking}), 32'h0);
    tick(10);
    lit("masked_stays0", 32'({owner, blanking}), 32'h0);
    req[1] = 1'b0;
    tick(1);
    req[1] = 1'b1;
    tick(1);
    lit("unmask_gap", 32'(blanking), 32'h1);
    tick(4);
    lit("unmask_owner1", 32'({owner, blanking}), 32'h2);

    // Short source-2 pulse inside the gap is not granted.
    req[2] = 1'b1;
    tick(1);
    req[2] = 1'b0;
    tick(4);
    lit("pulse_owner1", 32'({owner, blanking}), 32'h2);
    req[2] = 1'b1;
    tick(1);
    req[2] = 1'b0;
    req[1] = 1'b0;
    tick(4);
    lit("pulse_owner0", 32'({owner, blanking}), 32'h0);

    // Asynchronous reset in the middle of a gap.
    req[2] = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
    lit("async_rst_out", 32'({seg, an, dp}), 32'hFFF);
    lit("async_rst_state", 32'({owner, blanking}), 32'h0);
    req = '0;
    tick(2);
    rst = 1'b1;
    tick(1);
    lit("rst_release_seg", 32'({seg, blanking}), 32'h22);

    // Random traffic, checked by the model only.
    rand_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) req = NS'($urandom);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Parametrised N-source arbiter for the shared 4-digit 7-segment display, generalising the fixed two-way ALU-input/result mux in the calculator top level. Each source (operand entry, result, error, menus, …) presents its own seg/an/dp pattern plus a request. The arbiter grants ownership by fixed priority with minimum hold time, inserts a blanking gap on every handover to prevent ghosting, and enforces an optional ownership timeout that returns the display to source 0. It sits between the source controllers and the board pins; all outputs are registered.

## Interface
- N_SRC, 2: number of sources (2..8); source 0 is the default owner, higher index = higher priority
- SEG_W, 7: segment bus width per source
- AN_W, 4: anode bus width per source
- BLANK_CYC, 1000: blanking gap length in clk cycles (≥1)
- HOLD_CYC, 50000: minimum ownership before a lower-priority handover (0 = none)
- TIMEOUT_CYC, 0: maximum ownership of a non-zero source while its req stays high (0 = disabled)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req  in  N_SRC  level request per source; req[0] is ignored (treated as 1)
- seg_in  in  N_SRC*SEG_W  flattened segment patterns, source k at [k*SEG_W +: SEG_W]
- an_in  in  N_SRC*AN_W  flattened anode patterns, same packing
- dp_in  in  N_SRC  decimal point per source
- seg  out  SEG_W  registered segment output (active-low)
- an  out  AN_W  registered anode output (active-low)
- dp  out  1  registered decimal point (active-low)
- owner  out  clog2(N_SRC)  index of current owner
- blanking  out  1  high while in BLANK

## Operation
- target = highest index k with req[k]=1 and mask[k]=0; 0 if none.
- FSM states: OWN, BLANK.
- OWN: seg/an/dp ← inputs of owner. hold_cnt increments, saturating.
  - target > owner: go BLANK immediately (preemption ignores hold).
  - target < owner and hold_cnt ≥ HOLD_CYC: go BLANK.
  - TIMEOUT_CYC>0, owner≠0, hold_cnt ≥ TIMEOUT_CYC-1: set mask[owner], go BLANK.
  - Simultaneous preemption and timeout: both apply (mask set, BLANK entered once).
- BLANK: seg=all-ones, an=all-ones, dp=1 for exactly BLANK_CYC cycles; on the last cycle sample target, load it as owner, clear hold_cnt, return to OWN. Target changes during BLANK are not acted on until the end; if the final target equals the previous owner, ownership resumes after the full gap.
- mask[k] clears in the cycle after req[k] is seen low; mask[0] is always 0.
- Reset values: state OWN, owner 0, hold_cnt 0, mask 0, seg all-ones, an all-ones, dp 1, blanking 0. Reset mid-BLANK aborts the gap with no residual state.

## Timing
- One-cycle latency: outputs at edge t+1 reflect seg_in/an_in/dp_in of owner sampled at edge t.
- Owner request change to blanking=1: 1 cycle (preemption path).
- Gap: blanking high for exactly BLANK_CYC consecutive cycles; new owner data appears in the cycle blanking falls.
- Counters sized by clog2 of the largest of BLANK_CYC, HOLD_CYC, TIMEOUT_CYC; no wrap (saturate).

## Structure
- Shared defines header gains SEG_OFF/AN_OFF blank constants and the source index map (SRC_INPUT=0, SRC_RESULT=1, SRC_ERROR=2).
- One sub-module: src_prio_enc (masked highest-index priority encoder, combinational, N_SRC parametrised).
- Calculator top level instantiates this with N_SRC=2 in place of its inline mux.

## Test plan
Parameters N_SRC=3, BLANK_CYC=4, HOLD_CYC=8, TIMEOUT_CYC=20.
- Reset low mid-operation -> seg=7'h7F, an=4'hF, dp=1, owner=0 asynchronously; after release, cycle+1 shows source 0 pattern.
- req[1] rises at cycle 10 -> blanking high cycles 11-14, owner=1 and seg=seg_in[1] at cycle 15.
- Owner 1, req[1] drops at hold_cnt=3 -> no switch until hold_cnt=8, then 4-cycle blank, owner=0.
- Owner 1, req[2] rises at hold_cnt=2 -> immediate blank (hold ignored), owner=2 after 4 cycles.
- req[1] held high continuously -> owner 1 for 20 cycles, blank 4, owner 0; stays 0 until req[1] pulses low then high, then owner 1 again.
- req[2] pulses high then low within BLANK -> at end of gap owner = current target (1 or 0), not 2.
